// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor: one decimal digit per clock, LSD first.
// Optional input digit validation is compiled in with `define BCD_DIGIT_CHECK_EN.
module bcd_serial_addsub #(
  parameter int NDIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NDIGITS-1:0]   a,
  input  logic [4*NDIGITS-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NDIGITS-1:0]   sum,
  output logic                   cout
`ifdef BCD_DIGIT_CHECK_EN
  ,
  output logic                   err
`endif
);

  localparam int W  = 4 * NDIGITS;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NDIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_q, b_q;
  logic            sub_q;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [3:0]      a_dig, b_dig, dig;
  logic            carry_nxt;

  // Subtraction uses the nines complement of B with the carry seeded to 1.
  function automatic logic [4:0] digit_add(input logic [3:0] x, input logic [3:0] y,
                                           input logic s, input logic c);
    logic [3:0] yb;
    logic [4:0] t;
    yb = s ? (4'd9 - y) : y;
    t  = {1'b0, x} + {1'b0, yb} + {4'b0000, c};
    if (t > 5'd9)
      return {1'b1, 4'(t + 5'd6)};
    else
      return {1'b0, t[3:0]};
  endfunction

`ifdef BCD_DIGIT_CHECK_EN
  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NDIGITS; i++)
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  logic err_q;
`endif

  always_comb begin
    a_dig = a_q[3:0];
    b_dig = b_q[3:0];
    {carry_nxt, dig} = digit_add(a_dig, b_dig, sub_q, carry);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (idx == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands shift right so the active digit is always in the low nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sub_q <= 1'b0;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
      err_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= sub;
            idx   <= '0;
            carry <= sub;
`ifdef BCD_DIGIT_CHECK_EN
            err_q <= has_bad_digit(a) | has_bad_digit(b);
`endif
          end
        end
        RUN: begin
          sum[{idx, 2'b00} +: 4] <= dig;
          a_q   <= a_q >> 4;
          b_q   <= b_q >> 4;
          carry <= carry_nxt;
          if (idx == LAST) begin
            idx  <= '0;
            cout <= carry_nxt;
          end else begin
            idx  <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
`ifdef BCD_DIGIT_CHECK_EN
  assign err  = err_q & done;
`endif

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Randomized self-checking bench for bcd_serial_addsub (NDIGITS=4) against a decimal
// integer reference model; err checks are included when BCD_DIGIT_CHECK_EN is defined.
module tb_bcd_serial_addsub;

  localparam int N   = 4;
  localparam longint MOD = 10000;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          sub;
  logic [15:0]   a, b;
  logic          busy, done, cout;
  logic [15:0]   sum;
`ifdef BCD_DIGIT_CHECK_EN
  logic          err;
`endif

  int tests = 0;
  int fails = 0;

  bcd_serial_addsub #(.NDIGITS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef BCD_DIGIT_CHECK_EN
    ,
    .err   (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint bcd2int(input logic [15:0] v);
    longint r;
    r = 0;
    for (int i = N - 1; i >= 0; i--) r = r * 10 + longint'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input longint x);
    logic [15:0] r;
    longint      t;
    t = x;
    for (int i = 0; i < N; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] r;
    for (int i = 0; i < N; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  function automatic logic any_bad(input logic [15:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < N; i++) if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  // Decimal reference: add wraps mod 10^N with carry; subtract gives ten's complement on borrow.
  task automatic model(input logic [15:0] av, input logic [15:0] bv, input logic s,
                       output logic [15:0] esum, output logic ecout);
    longint ai, bi, t;
    ai = bcd2int(av);
    bi = bcd2int(bv);
    if (!s) begin
      t     = ai + bi;
      ecout = (t >= MOD);
      esum  = int2bcd(t % MOD);
    end else if (ai >= bi) begin
      ecout = 1'b1;
      esum  = int2bcd(ai - bi);
    end else begin
      ecout = 1'b0;
      esum  = int2bcd(MOD + ai - bi);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after done.
  task automatic run_op(input string nm, input logic [15:0] av, input logic [15:0] bv,
                        input logic s, input bit chk_res);
    logic [15:0] esum;
    logic        ecout;
    int          lat, bc;
    logic [15:0] sum_seen;
    model(av, bv, s, esum, ecout);
    a = av; b = bv; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    lat = 0;
    bc  = 0;
    for (int k = 1; k <= N + 4; k++) begin
      if (busy) bc++;
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    chk({nm, "_latency"}, lat, N + 1);
    chk({nm, "_busy_cycles"}, bc, N);
    if (chk_res) begin
      chk({nm, "_sum"}, sum, esum);
      chk({nm, "_cout"}, cout, ecout);
    end
`ifdef BCD_DIGIT_CHECK_EN
    chk({nm, "_err_done"}, err, any_bad(av) | any_bad(bv));
`endif
    sum_seen = sum;
    @(negedge clk);
    chk({nm, "_done_pulse"}, done, 0);
    chk({nm, "_sum_hold"}, sum, sum_seen);
`ifdef BCD_DIGIT_CHECK_EN
    chk({nm, "_err_idle"}, err, 0);
`endif
  endtask

  initial begin
    int          dcount;
    logic [15:0] held_sum;
    logic        held_cout;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    rst_n = 1'b1;

    run_op("add_1234_5678", 16'h1234, 16'h5678, 1'b0, 1'b1);
    chk("add_1234_5678_abs_sum", sum, 16'h6912);
    run_op("add_9999_0001", 16'h9999, 16'h0001, 1'b0, 1'b1);
    chk("add_9999_0001_abs_cout", cout, 1);
    run_op("sub_5000_1234", 16'h5000, 16'h1234, 1'b1, 1'b1);
    chk("sub_5000_1234_abs_sum", sum, 16'h3766);
    run_op("sub_0000_0001", 16'h0000, 16'h0001, 1'b1, 1'b1);
    chk("sub_0000_0001_abs_sum", sum, 16'h9999);
    run_op("sub_equal", 16'h4321, 16'h4321, 1'b1, 1'b1);

    for (int i = 0; i < 25; i++)
      run_op($sformatf("rand%0d", i), rand_bcd(), rand_bcd(), 1'($urandom), 1'b1);

    // A second start two cycles into RUN must be dropped.
    dcount = 0;
    held_sum = '0;
    held_cout = 1'b1;
    a = 16'h1234; b = 16'h5678; sub = 1'b0; start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 2) begin a = 16'h9999; b = 16'h8888; sub = 1'b1; start = 1'b1; end
      if (k == 3) start = 1'b0;
      if (done) begin
        dcount++;
        held_sum  = sum;
        held_cout = cout;
      end
    end
    chk("restart_done_count", dcount, 1);
    chk("restart_sum", held_sum, 16'h6912);
    chk("restart_cout", held_cout, 0);

    // Reset while digit 2 is in flight.
    a = 16'h5555; b = 16'h4444; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", cout, 0);
    dcount = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("midrst_no_done", dcount, 0);
    rst_n = 1'b1;
    run_op("post_rst_0001_0001", 16'h0001, 16'h0001, 1'b0, 1'b1);
    chk("post_rst_abs_sum", sum, 16'h0002);

`ifdef BCD_DIGIT_CHECK_EN
    run_op("bad_digit", 16'h00A0, 16'h0000, 1'b0, 1'b0);
    run_op("good_after_bad", 16'h0042, 16'h0017, 1'b0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bcd_serial_addsub.md
BCD_SERIAL_ADDSUB -- requirements
Module: bcd_serial_addsub

Interface
REQ-001 Parameter NDIGITS, default 4, SHALL set the operand width in BCD digits (legal range 1..16).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request an operation; sampled only in IDLE.
REQ-005 sub  input  1  SHALL select the operation: 0 = A+B, 1 = A-B; latched with start.
REQ-006 a  input  4*NDIGITS  SHALL carry operand A as packed BCD, digit 0 in bits [3:0].
REQ-007 b  input  4*NDIGITS  SHALL carry operand B as packed BCD, same packing as a.
REQ-008 busy  output  1  SHALL be high while in RUN.
REQ-009 done  output  1  SHALL be a one-cycle pulse marking a valid result.
REQ-010 sum  output  4*NDIGITS  SHALL carry the packed BCD result.
REQ-011 cout  output  1  SHALL carry the final decimal carry (add) or the no-borrow flag (sub).
REQ-012 err  output  1  SHALL flag an invalid input digit; present only when BCD_DIGIT_CHECK_EN is defined.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 IDLE with start=1 SHALL latch a, b and sub, set the digit index to 0, set the carry to sub, and go to RUN.
REQ-015 Each RUN cycle SHALL process exactly one digit i: B' = sub ? (9 - b_i) : b_i; T = a_i + B' + carry (5-bit).
REQ-016 If T > 9, sum digit i SHALL be (T + 6) mod 16 and the carry SHALL become 1; otherwise sum digit i SHALL be T and the carry SHALL become 0.
REQ-017 After digit NDIGITS-1, RUN SHALL go to DONE; DONE SHALL assert done for one cycle, drive cout = final carry, and return to IDLE.
REQ-018 Latency SHALL be fixed: done SHALL be high exactly NDIGITS+1 cycles after the edge that samples start.
REQ-019 Subtract semantics: cout=1 SHALL mean A>=B with sum = A-B; cout=0 SHALL mean A<B with sum = ten's complement of (B-A).
REQ-020 start SHALL be ignored in RUN and DONE; there SHALL be no queuing; a new start SHALL be accepted only in IDLE, at the earliest the cycle after done.
REQ-021 sum and cout SHALL hold their last values from done until the next accepted start; partial digits MAY change during RUN.
REQ-022 Inputs a, b and sub SHALL NOT affect an operation after they are latched.

Reset
REQ-023 rst_n low SHALL, asynchronously, force IDLE, busy=0, done=0, sum=0, cout=0, carry=0, index=0 (and err=0), including mid-RUN; the aborted operation SHALL produce no done.
REQ-024 After rst_n deasserts, the first start SHALL be accepted on the first rising clock edge.

Configuration
REQ-025 Macro BCD_DIGIT_CHECK_EN defined: at latch, any a or b digit > 9 SHALL set an internal error flag; err SHALL equal that flag during the done pulse and be 0 otherwise; sum and cout are still computed per REQ-015/016.
REQ-026 Macro BCD_DIGIT_CHECK_EN undefined: the err port and its logic SHALL be absent; results for non-BCD inputs are unspecified but SHALL still follow the REQ-018 timing.

Verification (NDIGITS=4)
REQ-027 add a=1234, b=5678 -> done at cycle 5 after start, sum=6912, cout=0.
REQ-028 add a=9999, b=0001 -> sum=0000, cout=1; busy high for exactly 4 cycles.
REQ-029 sub a=5000, b=1234 -> sum=3766, cout=1; sub a=0000, b=0001 -> sum=9999, cout=0.
REQ-030 start pulsed again 2 cycles into RUN with different operands -> ignored; the first result is unchanged and there is exactly one done.
REQ-031 rst_n pulled low during RUN digit 2 -> all outputs 0 immediately, no done; the next start (0001+0001) gives sum=0002.
REQ-032 With BCD_DIGIT_CHECK_EN defined, a=00A0, b=0000 -> err=1 coincident with done; a valid operation that follows gives err=0.
